// File: rtl/ram_read_streamer.sv
// ram_read_streamer: read-side burst controller for port B of the simple dual
// port RAM. Issues sequential reads, tracks them through the RAM read pipeline
// with a tag shift register, buffers returned words in a credit-protected FIFO
// and presents them as a valid/ready stream with a last flag.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           burst command strobe (sampled only while idle)
//   start_addr      first word address
//   len             number of words, 0..MEM_DEPTH
//   busy            high from command acceptance until burst completion
//   done            one-cycle completion pulse
//   ram_addrb       RAM port B address
//   ram_renb        RAM port B read enable (advances the RAM read pipeline)
//   ram_doutb       RAM port B read data
//   m_data/m_valid/m_ready/m_last   output stream
module ram_read_streamer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned RD_LATENCY = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_renb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned INF_W = $clog2(RD_LATENCY + 1);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cap_cnt_q, cap_cnt_d;
  logic [RD_LATENCY-1:0] tag_q, tag_d;
  entry_t                fifo_q [FIFO_DEPTH];
  entry_t                fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic                  issue;
  logic                  pop;
  logic                  last_pop;
  logic                  capture;
  logic [INF_W-1:0]      inflight;
  logic [OCC_W-1:0]      occ;
  logic                  credit_ok;
  entry_t                cap_entry;
  entry_t                head;

  assign busy      = busy_q;
  assign ram_renb  = busy_q;
  assign done      = done_q;
  assign ram_addrb = addr_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_data    = m_data_q;

  // Handshake and credit: words in flight plus buffered words, less the word
  // leaving this cycle, must leave room for one more issue.
  always_comb begin
    pop      = m_valid_q & m_ready;
    last_pop = pop & m_last_q;
    inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight = inflight + INF_W'(tag_q[i]);
    end
    occ       = OCC_W'(count_q) + OCC_W'(inflight) - OCC_W'(pop);
    credit_ok = (occ < OCC_W'(FIFO_DEPTH));
  end

  // Burst control FSM: next state, issue decision and status outputs.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = start_addr;
            rem_d   = len;
            len_d   = len;
            busy_d  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if ((rem_q != '0) && credit_ok) begin
          issue  = 1'b1;
          addr_d = (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last word can be consumed in the same cycle inflight empties.
        if (last_pop) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (inflight == '0) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (last_pop) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipe mirrors the RAM read pipeline; a 1-tag exiting marks valid data.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = issue;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      tag_d[i] = tag_q[i-1];
    end
    capture = tag_q[RD_LATENCY-1];
  end

  // Output FIFO with registered head: m_data/m_last/m_valid reflect the
  // post-update head so the stream outputs are plain flops.
  always_comb begin
    cap_entry.last = ((cap_cnt_q + LEN_W'(1)) == len_q);
    cap_entry.data = ram_doutb;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cap_cnt_d = cap_cnt_q;
    if (capture) begin
      fifo_d[wr_ptr_q] = cap_entry;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      cap_cnt_d        = cap_cnt_q + LEN_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (state_q == IDLE) begin
      cap_cnt_d = '0;
    end
    count_d   = count_q + CNT_W'(capture) - CNT_W'(pop);
    head      = fifo_d[rd_ptr_d];
    m_valid_d = (count_d != '0);
    m_last_d  = m_valid_d & head.last;
    m_data_d  = head.data;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      cap_cnt_q <= '0;
      tag_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      cap_cnt_q <= cap_cnt_d;
      tag_q     <= tag_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule

// File: tb/tb_ram_read_streamer.sv
// Directed bench for ram_read_streamer with a behavioural port-B RAM model.
module tb_ram_read_streamer;

  localparam int unsigned DW = 32;
  localparam int unsigned MD = 1024;
  localparam int unsigned AW = 10;
  localparam int unsigned L  = 3;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addrb;
  logic          ram_renb;
  logic [DW-1:0] ram_doutb;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  always #5 clk = ~clk;

  ram_read_streamer #(
    .DATA_WIDTH(DW), .MEM_DEPTH(MD), .RD_LATENCY(L), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_addrb(ram_addrb), .ram_renb(ram_renb),
    .ram_doutb(ram_doutb), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  // RAM model: read pipeline of L stages, advanced by the read enable.
  logic [DW-1:0] mem   [MD];
  logic [DW-1:0] rpipe [L];
  always @(posedge clk) begin
    if (ram_renb) begin
      rpipe[0] <= mem[ram_addrb];
      for (int i = 1; i < int'(L); i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign ram_doutb = rpipe[L-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor, sampled on the falling edge.
  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  int            rx_cyc  [$];
  int            first_valid = -1;
  int            done_cnt = 0;
  int            stall_err = 0;
  int            max_occ = 0;
  int            max_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        rx_data.push_back(m_data);
        rx_last.push_back(m_last);
        rx_cyc.push_back(cyc);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) done_cnt++;
      if (int'(dut.count_q) + int'(dut.inflight) > max_occ) max_occ = int'(dut.count_q) + int'(dut.inflight);
      if (int'(dut.count_q) > max_cnt) max_cnt = int'(dut.count_q);
    end
  end

  // mode 0: ready always; 1: ready low for `stall` cycles; 2: random ready.
  task automatic do_burst(input logic [AW-1:0] a, input logic [AW:0] n, input int mode,
                          input int stall, input bit inject, input bit gapless, input string tag);
    int k;
    int start_cyc;
    logic [DW-1:0] exp;
    rx_data.delete(); rx_last.delete(); rx_cyc.delete();
    first_valid = -1;
    done_cnt    = 0;
    m_ready     = (mode == 0);
    start       = 1'b1;
    start_addr  = a;
    len         = n;
    start_cyc   = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      case (mode)
        1:       m_ready = (k >= stall);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      if (inject && k == 2) begin
        start = 1'b1; start_addr = '0; len = 11'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    check_val({tag, "_done"}, 64'(done), 64'd1);
    check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_busy_after"}, 64'(busy), 64'd0);
    check_val({tag, "_count"}, 64'(rx_data.size()), 64'(n));
    if (gapless) check_val({tag, "_latency"}, 64'(first_valid - start_cyc), 64'(L + 2));
    for (int i = 0; i < rx_data.size() && i < int'(n); i++) begin
      exp = 32'h100 + 32'((int'(a) + i) % int'(MD));
      check_val($sformatf("%s_data%0d", tag, i), 64'(rx_data[i]), 64'(exp));
      check_val($sformatf("%s_last%0d", tag, i), 64'(rx_last[i]), 64'(i == int'(n) - 1));
      if (gapless) check_val($sformatf("%s_gap%0d", tag, i), 64'(rx_cyc[i] - rx_cyc[0]), 64'(i));
    end
  endtask

  initial begin
    for (int i = 0; i < int'(MD); i++) mem[i] = 32'h100 + 32'(i);
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    m_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_ctl", 64'({busy, done, ram_renb, m_valid, m_last}), 64'd0);
    check_val("reset_addr", 64'(ram_addrb), 64'd0);
    check_val("reset_data", 64'(m_data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst, full throughput.
    do_burst(10'd5, 11'd4, 0, 0, 1'b0, 1'b1, "basic");

    // Address wrap, with a start during the burst that must be ignored.
    do_burst(10'd1022, 11'd4, 0, 0, 1'b1, 1'b1, "wrap");

    // Zero-length command.
    start = 1'b1; start_addr = 10'd9; len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("len0_done", 64'(done), 64'd1);
    check_val("len0_busy", 64'(busy), 64'd0);
    check_val("len0_renb", 64'(ram_renb), 64'd0);
    @(posedge clk); #1;
    check_val("len0_done_pulse", 64'({done, busy, ram_renb}), 64'd0);

    // Downstream stall: FIFO fills exactly, nothing lost.
    max_occ = 0;
    max_cnt = 0;
    do_burst(10'd40, 11'd16, 1, 20, 1'b0, 1'b0, "stall");
    check_val("stall_max_fifo", 64'(max_cnt), 64'(FD));
    check_val("stall_max_occ", 64'(max_occ), 64'(FD));

    // Random backpressure.
    max_occ = 0;
    do_burst(10'd200, 11'd64, 2, 0, 1'b0, 1'b0, "rand");
    check_val("rand_max_occ_le", 64'(max_occ <= int'(FD)), 64'd1);

    // Reset in the middle of a burst.
    m_ready = 1'b0;
    start = 1'b1; start_addr = 10'd300; len = 11'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("pre_rst_valid", 64'({busy, m_valid}), 64'd3);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_ctl", 64'({busy, done, ram_renb, m_valid, m_last}), 64'd0);
    check_val("midrst_addr", 64'(ram_addrb), 64'd0);
    check_val("midrst_data", 64'(m_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_burst(10'd100, 11'd3, 0, 0, 1'b0, 1'b1, "post_rst");

    check_val("stall_stable", 64'(stall_err), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
